// File: rtl/syn_fifo_param.sv
// syn_fifo_param: single-clock FIFO with FWFT option, thresholds, count and sticky errors
//   clk, rst (sync, active-high); wr_en/wdata -> full/almost_full/overflow;
//   rd_en -> rdata/rd_valid/empty/almost_empty/underflow; count = occupancy;
//   err_clr clears ovf_sticky/udf_sticky.
module syn_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wdata,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     almost_empty,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     err_clr,
  output logic                     ovf_sticky,
  output logic                     udf_sticky
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] CNT_AE   = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0] wptr, rptr;
  logic wr_ok, rd_ok, ovf_req, udf_req;
  // Pointers carry a wrap bit, so plain subtraction yields 0..DEPTH with no special case.
  assign count        = wptr - rptr;
  assign full         = count == CNT_FULL;
  assign empty        = count == '0;
  assign almost_full  = count >= CNT_AF;
  assign almost_empty = count <= CNT_AE;
  assign ovf_req      = !rst && wr_en && full;
  assign udf_req      = !rst && rd_en && empty;
  assign wr_ok        = !rst && wr_en && !full;
  assign rd_ok        = !rst && rd_en && !empty;
  always_ff @(posedge clk)
    if (wr_ok) mem[wptr[ADDR_W-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      wptr       <= wr_ok ? wptr + ONE : wptr;
      rptr       <= rd_ok ? rptr + ONE : rptr;
      overflow   <= ovf_req;
      underflow  <= udf_req;
      // A new error outranks a coincident clear.
      ovf_sticky <= ovf_req || (ovf_sticky && !err_clr);
      udf_sticky <= udf_req || (udf_sticky && !err_clr);
    end
  end
  if (FWFT != 0) begin : g_fwft
    assign rdata    = empty ? '0 : mem[rptr[ADDR_W-1:0]];
    assign rd_valid = !empty;
  end else begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata    <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_ok;
        if (rd_ok) rdata <= mem[rptr[ADDR_W-1:0]];
      end
    end
  end
endmodule
